// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared widths and FSM state type for the RAM address controller.
package ram_ctrl_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, STEP, WAIT, CAPTURE} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, debouncer and falling-edge press detector for one active-low button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level, level_d;
  // cnt counts consecutive synchronized samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      level <= 1'b1;
      level_d <= 1'b1;
      cnt <= '0;
    end else begin
      sync <= {sync[0], btn};
      level_d <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign press = level_d & ~level;
endmodule

// File: rtl/ram_addr_ctrl.sv
// ram_addr_ctrl: button-driven RAM read address stepper that captures RAM read data after a fixed latency.
module ram_addr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        btn,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy
);
  localparam int WW = $clog2(READ_LATENCY + 1);
  logic [2:0] press, ev;
  logic [ADDR_W-1:0] next_addr;
  logic [WW-1:0] wcnt;
  state_t state;
  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .btn(btn[i]),
      .press(press[i])
    );
  end
  // clear wins; increment and decrement together cancel
  always_comb begin
    next_addr = ev[2] ? '0 :
                (ev[0] & ev[1]) ? address :
                ev[0] ? address + 1'b1 :
                ev[1] ? address - 1'b1 : address;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      address <= '0;
      data <= '0;
      data_valid <= 1'b0;
      busy <= 1'b0;
      ev <= '0;
      wcnt <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: if (|press) begin
          ev <= press;
          busy <= 1'b1;
          state <= STEP;
        end
        STEP: begin
          address <= next_addr;
          wcnt <= '0;
          state <= WAIT;
        end
        WAIT: if (wcnt == WW'(READ_LATENCY - 1)) begin
          data <= q;
          data_valid <= 1'b1;
          state <= CAPTURE;
        end else wcnt <= wcnt + 1'b1;
        CAPTURE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_addr_ctrl.sv
// tb_ram_addr_ctrl: scoreboard bench for ram_addr_ctrl with a behavioural RAM (mem[a] = a[7:0] ^ 8'hA5).
module tb_ram_addr_ctrl;
  localparam int DEB = 4;
  localparam int RL = 2;
  localparam int LAT = 2 + DEB + RL + 2;
  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
    int          t0;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] btn = 3'b111;
  logic [7:0] q;
  logic [13:0] address;
  logic [7:0] data;
  logic data_valid, busy;
  logic [13:0] m_addr = '0;
  exp_t sb[$];
  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // data is ready by the end of the second cycle the address is presented
  always @(posedge clk) q <= address[7:0] ^ 8'hA5;
  ram_addr_ctrl #(.DEBOUNCE_CYCLES(DEB), .READ_LATENCY(RL)) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .q(q),
    .address(address),
    .data(data),
    .data_valid(data_valid),
    .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      exp_t e;
      if (sb.size() == 0) check("spurious_dv", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("addr", 32'(address), 32'(e.a));
        check("data", 32'(data), 32'(e.d));
        check("latency", 32'(cyc - e.t0), 32'(LAT));
        check("busy_at_dv", 32'(busy), 32'd1);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_step(input logic [2:0] m);
    exp_t e;
    m_addr = m[2] ? 14'd0 : (m[0] & m[1]) ? m_addr : m[0] ? m_addr + 14'd1 : m[1] ? m_addr - 14'd1 : m_addr;
    e.a = m_addr;
    e.d = m_addr[7:0] ^ 8'hA5;
    e.t0 = cyc;
    sb.push_back(e);
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 80) begin
      tick(1);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    tick(12);
  endtask
  task automatic press(input logic [2:0] m, input int hold);
    expect_step(m);
    btn = ~m;
    tick(hold);
    btn = 3'b111;
    drain();
  endtask
  initial begin
    tick(3);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(50);
    check("idle_addr", 32'(address), 32'd0);
    check("idle_data", 32'(data), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    press(3'b001, 10);
    press(3'b010, 10);
    press(3'b010, 10);
    check("wrap_down", 32'(address), 32'd16383);
    press(3'b001, 10);
    check("wrap_up", 32'(address), 32'd0);
    btn = 3'b101;
    tick(2);
    btn = 3'b111;
    tick(20);
    check("glitch_addr", 32'(address), 32'(m_addr));
    repeat (5) press(3'b001, 8);
    check("preload5", 32'(address), 32'd5);
    press(3'b101, 10);
    press(3'b011, 10);
    check("inc_dec_cancel", 32'(address), 32'd0);
    // second button lands two cycles after the first press event, inside the busy window
    expect_step(3'b001);
    btn = 3'b110;
    tick(2);
    btn = 3'b100;
    tick(10);
    btn = 3'b111;
    drain();
    check("busy_discard", 32'(address), 32'(m_addr));
    begin
      int n = 0;
      btn = 3'b110;
      while (!busy && n < 40) begin
        tick(1);
        n++;
      end
      check("busy_rise", 32'(busy), 32'd1);
      tick(2);
      rst = 1'b1;
      btn = 3'b111;
      tick(1);
      check("abort_addr", 32'(address), 32'd0);
      check("abort_data", 32'(data), 32'd0);
      check("abort_dv", 32'(data_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      m_addr = '0;
      tick(30);
      check("post_abort_addr", 32'(address), 32'd0);
      check("post_abort_busy", 32'(busy), 32'd0);
    end
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
